// File: rtl/reg_rename_file_pkg.sv
// reg_rename_file_pkg
// Shared sizing constants and types for the rename-tagged architectural register file.
// Contents:
//   ROB_WIDTH / ROB_SIZE   - ROB index width and depth
//   XLEN                   - register data width
//   NREG / REG_IDX_W       - architectural register count and index width
//   ZERO_REG               - index of the hardwired-zero register
//   read_src_e             - which source a read port selected
//   is_arch_writable()     - true for any register other than x0
package reg_rename_file_pkg;

  localparam int ROB_WIDTH = 4;
  localparam int ROB_SIZE  = 1 << ROB_WIDTH;
  localparam int XLEN      = 32;
  localparam int NREG      = 32;
  localparam int REG_IDX_W = 5;

  typedef logic [ROB_WIDTH-1:0] rob_id_t;
  typedef logic [XLEN-1:0]      xlen_t;
  typedef logic [REG_IDX_W-1:0] reg_idx_t;

  localparam reg_idx_t ZERO_REG = '0;

  // Listed in decreasing priority order of the read mux.
  typedef enum logic [2:0] {
    SRC_ZERO,
    SRC_REG,
    SRC_BYPASS,
    SRC_ROB,
    SRC_PENDING
  } read_src_e;

  function automatic logic is_arch_writable(input reg_idx_t idx);
    return idx != ZERO_REG;
  endfunction

endpackage

// File: rtl/reg_rename_file_if.sv
// reg_rename_file_if
// Bundles every non-clock/reset signal of the rename register file.
// Signal groups:
//   control : rdy_in (global stall when low), clear (mispredict flush)
//   decode  : dec_ready, dec_rd, dec_rob_id, rs1_id, rs2_id
//   operand : rs1/rs2 val, dep, tag (results back to dispatch)
//   search  : search_rob_id_1/2 out, search_ready_1/2 and search_val_1/2 in (ROB lookups)
//   commit  : commit_valid, commit_rob_id, commit_reg_id, commit_val (from ROB)
// Modports:
//   slave  - the register file itself
//   master - the surrounding decoder/ROB environment
interface reg_rename_file_if;
  import reg_rename_file_pkg::*;

  logic     rdy_in;
  logic     clear;

  logic     dec_ready;
  reg_idx_t dec_rd;
  rob_id_t  dec_rob_id;
  reg_idx_t rs1_id;
  reg_idx_t rs2_id;

  xlen_t    rs1_val;
  xlen_t    rs2_val;
  logic     rs1_dep;
  logic     rs2_dep;
  rob_id_t  rs1_tag;
  rob_id_t  rs2_tag;

  rob_id_t  search_rob_id_1;
  rob_id_t  search_rob_id_2;
  logic     search_ready_1;
  logic     search_ready_2;
  xlen_t    search_val_1;
  xlen_t    search_val_2;

  logic     commit_valid;
  rob_id_t  commit_rob_id;
  reg_idx_t commit_reg_id;
  xlen_t    commit_val;

  modport slave (
    input  rdy_in, clear,
    input  dec_ready, dec_rd, dec_rob_id, rs1_id, rs2_id,
    output rs1_val, rs2_val, rs1_dep, rs2_dep, rs1_tag, rs2_tag,
    output search_rob_id_1, search_rob_id_2,
    input  search_ready_1, search_ready_2, search_val_1, search_val_2,
    input  commit_valid, commit_rob_id, commit_reg_id, commit_val
  );

  modport master (
    output rdy_in, clear,
    output dec_ready, dec_rd, dec_rob_id, rs1_id, rs2_id,
    input  rs1_val, rs2_val, rs1_dep, rs2_dep, rs1_tag, rs2_tag,
    input  search_rob_id_1, search_rob_id_2,
    output search_ready_1, search_ready_2, search_val_1, search_val_2,
    output commit_valid, commit_rob_id, commit_reg_id, commit_val
  );

endinterface

// File: rtl/reg_rename_file_rename_read_port.sv
// rename_read_port
// Combinational operand resolution for one source register. Given the stored state of
// the addressed register, it picks the operand from (in priority order):
//   x0 -> 0, committed register value, same-cycle commit bypass,
//   ROB search result, else pending on the producing ROB tag.
// Ports:
//   i_rs_id, i_reg_val, i_busy, i_tag      - addressed register id and its stored state
//   i_commit_valid/_reg_id/_rob_id/_val    - commit happening this cycle
//   i_search_ready, i_search_val           - ROB search result for i_tag
//   o_val, o_dep, o_tag                    - resolved operand / pending flag / producer tag
//   o_search_rob_id                        - ROB slot to search (always the stored tag)
module rename_read_port
  import reg_rename_file_pkg::*;
(
  input  reg_idx_t i_rs_id,
  input  xlen_t    i_reg_val,
  input  logic     i_busy,
  input  rob_id_t  i_tag,
  input  logic     i_commit_valid,
  input  reg_idx_t i_commit_reg_id,
  input  rob_id_t  i_commit_rob_id,
  input  xlen_t    i_commit_val,
  input  logic     i_search_ready,
  input  xlen_t    i_search_val,
  output xlen_t    o_val,
  output logic     o_dep,
  output rob_id_t  o_tag,
  output rob_id_t  o_search_rob_id
);

  read_src_e w_src;

  assign o_search_rob_id = i_tag;

  // The commit bypass must match the tag too: a commit from an older rename of the
  // same register is stale and must not satisfy the current producer.
  always_comb begin
    w_src = SRC_PENDING;
    if (i_rs_id == ZERO_REG) begin
      w_src = SRC_ZERO;
    end else if (!i_busy) begin
      w_src = SRC_REG;
    end else if (i_commit_valid && (i_commit_reg_id == i_rs_id) &&
                 (i_commit_rob_id == i_tag)) begin
      w_src = SRC_BYPASS;
    end else if (i_search_ready) begin
      w_src = SRC_ROB;
    end
  end

  // The tag is only meaningful while pending; it reads 0 otherwise.
  always_comb begin
    o_val = '0;
    o_dep = 1'b0;
    o_tag = '0;
    case (w_src)
      SRC_ZERO:    o_val = '0;
      SRC_REG:     o_val = i_reg_val;
      SRC_BYPASS:  o_val = i_commit_val;
      SRC_ROB:     o_val = i_search_val;
      SRC_PENDING: begin
        o_dep = 1'b1;
        o_tag = i_tag;
      end
      default:     o_val = '0;
    endcase
  end

endmodule

// File: rtl/reg_rename_file.sv
// reg_rename_file
// Architectural register file with a rename tag per register. Decoder issues rename a
// destination onto a ROB slot; ROB commits write values back and retire the rename when
// the tag still matches. Two combinational read ports resolve source operands.
// Ports:
//   clk_in    - system clock
//   rst_in_n  - asynchronous active-low reset, clears all values, busy bits and tags
//   bus       - reg_rename_file_if.slave: control, decode, operand, ROB search, commit
module reg_rename_file
  import reg_rename_file_pkg::*;
(
  input  logic               clk_in,
  input  logic               rst_in_n,
  reg_rename_file_if.slave   bus
);

  xlen_t   r_regs [NREG];
  logic    r_busy [NREG];
  rob_id_t r_tag  [NREG];

  logic    w_commit_wr;
  logic    w_commit_retire;
  logic    w_issue_wr;

  assign w_commit_wr     = bus.commit_valid && is_arch_writable(bus.commit_reg_id);
  assign w_commit_retire = w_commit_wr && r_busy[bus.commit_reg_id] &&
                           (r_tag[bus.commit_reg_id] == bus.commit_rob_id);
  assign w_issue_wr      = bus.dec_ready && !bus.clear && is_arch_writable(bus.dec_rd);

  // Issue is applied after commit so that, for the same destination, the new rename
  // overrides the busy clear. Clear overrides both. A commit value write is never
  // suppressed by clear or by a same-cycle issue.
  always_ff @(posedge clk_in or negedge rst_in_n) begin
    if (!rst_in_n) begin
      for (int i = 0; i < NREG; i++) begin
        r_regs[i] <= '0;
        r_busy[i] <= 1'b0;
        r_tag[i]  <= '0;
      end
    end else if (bus.rdy_in) begin
      if (w_commit_wr) begin
        r_regs[bus.commit_reg_id] <= bus.commit_val;
      end
      if (w_commit_retire) begin
        r_busy[bus.commit_reg_id] <= 1'b0;
      end
      if (bus.clear) begin
        for (int i = 0; i < NREG; i++) begin
          r_busy[i] <= 1'b0;
        end
      end else if (w_issue_wr) begin
        r_busy[bus.dec_rd] <= 1'b1;
        r_tag[bus.dec_rd]  <= bus.dec_rob_id;
      end
    end
  end

  // Both ports read the pre-issue mapping, so an instruction never depends on itself.
  rename_read_port u_read_port_1 (
    .i_rs_id         (bus.rs1_id),
    .i_reg_val       (r_regs[bus.rs1_id]),
    .i_busy          (r_busy[bus.rs1_id]),
    .i_tag           (r_tag[bus.rs1_id]),
    .i_commit_valid  (bus.commit_valid),
    .i_commit_reg_id (bus.commit_reg_id),
    .i_commit_rob_id (bus.commit_rob_id),
    .i_commit_val    (bus.commit_val),
    .i_search_ready  (bus.search_ready_1),
    .i_search_val    (bus.search_val_1),
    .o_val           (bus.rs1_val),
    .o_dep           (bus.rs1_dep),
    .o_tag           (bus.rs1_tag),
    .o_search_rob_id (bus.search_rob_id_1)
  );

  rename_read_port u_read_port_2 (
    .i_rs_id         (bus.rs2_id),
    .i_reg_val       (r_regs[bus.rs2_id]),
    .i_busy          (r_busy[bus.rs2_id]),
    .i_tag           (r_tag[bus.rs2_id]),
    .i_commit_valid  (bus.commit_valid),
    .i_commit_reg_id (bus.commit_reg_id),
    .i_commit_rob_id (bus.commit_rob_id),
    .i_commit_val    (bus.commit_val),
    .i_search_ready  (bus.search_ready_2),
    .i_search_val    (bus.search_val_2),
    .o_val           (bus.rs2_val),
    .o_dep           (bus.rs2_dep),
    .o_tag           (bus.rs2_tag),
    .o_search_rob_id (bus.search_rob_id_2)
  );

endmodule

// File: doc/reg_rename_file.md
Name: reg_rename_file

Overview:
- Architectural register file with per-register rename tags for the out-of-order core.
- Sits between decoder, ROB and the dispatch path to RS/LSB.
- Receives ROB commits (the other end of the ROB commit interface) and drives the ROB search ports to resolve in-flight operands.
- Records the new rd→ROB-id mapping when the decoder issues an instruction.

Parameters:
ROB_WIDTH, 4, ROB index width (ROB_SIZE = 2**ROB_WIDTH)
XLEN, 32, register data width
NREG, 32, architectural registers (x0 hardwired zero)

Ports:
clk_in  in  1  system clock
rst_in_n  in  1  reset, asynchronous, active-low
rdy_in  in  1  global ready; state frozen when low
clear  in  1  ROB mispredict flush
dec_ready  in  1  decoder issues one instruction this cycle
dec_rd  in  5  destination of issued instruction
dec_rob_id  in  ROB_WIDTH  ROB slot allocated to it (ROB empty_rob_id)
rs1_id, rs2_id  in  5 each  source registers of the issuing instruction
rs1_val, rs2_val  out  XLEN each  operand value (valid when dep=0)
rs1_dep, rs2_dep  out  1 each  operand still pending
rs1_tag, rs2_tag  out  ROB_WIDTH each  producing ROB id when dep=1
search_rob_id_1, search_rob_id_2  out  ROB_WIDTH each  to ROB search ports
search_ready_1, search_ready_2  in  1 each  ROB entry has result
search_val_1, search_val_2  in  XLEN each  ROB entry result
commit_valid  in  1  commit strobe from ROB
commit_rob_id  in  ROB_WIDTH  committing ROB slot
commit_reg_id  in  5  committing destination
commit_val  in  XLEN  committed value

Behaviour:
- State: regs[NREG] XLEN, busy[NREG] 1b, tag[NREG] ROB_WIDTH.
- Reset (async, rst_in_n=0): all regs, busy and tag = 0. Read outputs are combinational; after reset they read val=0, dep=0, tag=0.
- Read path: fully combinational, zero latency; evaluated independently for rs1 and rs2.
  - search_rob_id_k = tag[rsk_id].
  - Priority per source:
    1. rsk_id==0 → val 0, dep 0.
    2. !busy → regs value, dep 0.
    3. commit_valid && commit_reg_id==rsk_id && commit_rob_id==tag → commit_val, dep 0 (bypass).
    4. search_ready_k → search_val_k, dep 0.
    5. Otherwise → dep 1, tag=tag[rsk_id], val 0.
- Reads always see the mapping before this cycle's issue (an instruction's sources precede its own rd rename).
- Sequential update, posedge clk_in, only when rdy_in=1. When rdy_in=0 all state holds.
- Commit: if commit_valid && commit_reg_id!=0:
  - regs[rd] <= commit_val.
  - If busy[rd] && tag[rd]==commit_rob_id → busy[rd] <= 0, unless overridden by issue.
  - A stale commit (tag mismatch) writes the value but leaves busy/tag untouched.
- Issue: if dec_ready && !clear && dec_rd!=0 → busy[dec_rd] <= 1, tag[dec_rd] <= dec_rob_id.
- Commit and issue to the same rd in one cycle: commit's value write occurs; issue wins for busy/tag (busy stays 1, new tag).
- Clear (rdy_in=1): all busy <= 0; regs keep values; a same-cycle commit value write still happens; same-cycle issue is dropped.
- x0: never written, never busy.
- ROB id wrap-around: tags compare by equality only. Stale-commit safety relies on commit_valid qualification and the ROB never holding two live entries with one id.
- Reset mid-operation: immediate async clear of all state regardless of rdy_in or clock.

Decomposition:
- Shared params package: ROB_WIDTH/ROB_SIZE, XLEN, NREG, register-index width (5), zero-register constant.
- One natural sub-module: rename_read_port (combinational priority mux for one source, instantiated twice).
- Storage and update logic live in reg_rename_file.

Test Plan:
1. Reset: drive rst_in_n=0 mid-run with busy[5]=1 → immediately rs1_id=5 gives val 0, dep 0; all regs read 0.
2. Issue rd=5 rob 3, next cycle read rs1=5 with search_ready_1=0 → dep 1, tag 3, search_rob_id_1=3; then search_ready_1=1, search_val_1=0xDEAD → dep 0, val 0xDEAD.
3. Commit rob 3 reg 5 val 0x1234 while reading rs2=5 the same cycle → bypass val 0x1234, dep 0; next cycle busy[5]=0, regs[5]=0x1234.
4. Issue rd=7 rob 2, then issue rd=7 rob 4; commit rob 2 reg 7 val 0x11 → regs[7]=0x11, busy stays 1, tag stays 4.
5. Same cycle commit rob 4 reg 9 (tag 4) plus issue rd=9 rob 6 → busy[9]=1, tag 6, regs[9]=commit_val.
6. clear=1 with busy on x3, x8 and dec_ready for rd=10 → all busy 0, x10 not renamed. rdy_in=0 with commit_valid=1 → no state change; rd=0 writes ignored.
